dmem_hs: RTL

//  Parametrised RV32/RV64 data memory with a valid/ready request/response handshake.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_ld_align.sv | 33 +++
 rtl/dmem_hs.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared funct3 codes, error codes and access-size decode
// for the handshaked data memory.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      ERR_OK    = 2'b00,
      ERR_MISAL = 2'b01,
      ERR_RANGE = 2'b10,
      ERR_ILL   = 2'b11
   } err_e;

   function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
      return 4'd1 << funct3[1:0];
   endfunction

endpackage

// File: rtl/dmem_ld_align.sv
// Load lane select and sign/zero extension on a registered word.
// Purely combinational.
module dmem_ld_align
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OFF_W      = $clog2(DATA_WIDTH/8)
) (
   input  logic [DATA_WIDTH-1:0] word,
   input  logic [OFF_W-1:0]      offset,
   input  logic [2:0]            funct3,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] sh;

   assign sh = word >> {offset, 3'b000};

   always_comb begin
      rdata = '0;
      case (funct3)
         F3_B:    rdata = DATA_WIDTH'($signed(sh[7:0]));
         F3_H:    rdata = DATA_WIDTH'($signed(sh[15:0]));
         F3_W:    rdata = DATA_WIDTH'($signed(sh[31:0]));
         F3_D:    rdata = sh;
         F3_BU:   rdata = DATA_WIDTH'(sh[7:0]);
         F3_HU:   rdata = DATA_WIDTH'(sh[15:0]);
         F3_WU:   rdata = DATA_WIDTH'(sh[31:0]);
         default: rdata = '0;
      endcase
   end

endmodule

// File: rtl/dmem_hs.sv
// Data memory with valid/ready request/response handshake,
// byte-lane writes, error responses and saturating counters.
module dmem_hs
   import dmem_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DEPTH      = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_err,
   output logic [CNT_WIDTH-1:0]  ld_cnt,
   output logic [CNT_WIDTH-1:0]  st_cnt,
   output logic [CNT_WIDTH-1:0]  err_cnt
);

   localparam int LANES = DATA_WIDTH/8;
   localparam int OFF_W = $clog2(LANES);
   localparam int IDX_W = $clog2(DEPTH);
   localparam bit IS64  = (DATA_WIDTH == 64);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] rel;
   logic [ADDR_WIDTH-1:0] widx;
   logic [IDX_W-1:0]      idx;
   logic [OFF_W-1:0]      off;
   logic [3:0]            size;
   logic                  legal;
   logic                  misal;
   logic                  range_err;
   err_e                  err;
   logic                  accept;
   logic                  we_ok;
   logic [LANES-1:0]      mask;
   logic [DATA_WIDTH-1:0] wsh;

   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] al_rdata;
   err_e                  rsp_err_q;
   logic                  ld_ok;
   logic [OFF_W-1:0]      rsp_off;
   logic [2:0]            rsp_f3;

   assign rel       = req_addr - BASE_ADDR;
   assign widx      = rel >> OFF_W;
   assign idx       = widx[IDX_W-1:0];
   assign off       = req_addr[OFF_W-1:0];
   assign size      = size_bytes(req_funct3);
   assign misal     = (req_addr[3:0] & (size - 4'd1)) != 4'd0;
   // Range is checked on the full address: no wrap into the array.
   assign range_err = (req_addr < BASE_ADDR) || (widx >= DEPTH_A);

   always_comb begin
      legal = 1'b0;
      if (req_we)
         legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) ||
                 (req_funct3 == F3_W) ||
                 (IS64 && (req_funct3 == F3_D));
      else
         legal = (req_funct3 == F3_B)  || (req_funct3 == F3_H)  ||
                 (req_funct3 == F3_W)  || (req_funct3 == F3_BU) ||
                 (req_funct3 == F3_HU) ||
                 (IS64 && ((req_funct3 == F3_D) ||
                           (req_funct3 == F3_WU)));
   end

   always_comb begin
      err = ERR_OK;
      priority case (1'b1)
         !legal:    err = ERR_ILL;
         misal:     err = ERR_MISAL;
         range_err: err = ERR_RANGE;
         default:   err = ERR_OK;
      endcase
   end

   assign req_ready = !rsp_valid || rsp_ready;
   assign accept    = req_valid && req_ready;
   assign we_ok     = accept && req_we && (err == ERR_OK);
   assign mask      = LANES'((9'd1 << size) - 9'd1) << off;
   assign wsh       = req_wdata << {off, 3'b000};

   always_ff @(posedge clk) begin
      if (rst_n && we_ok)
         for (int k = 0; k < LANES; k++)
            if (mask[k])
               mem[idx][8*k +: 8] <= wsh[8*k +: 8];
      if (accept && !req_we)
         rd_word <= mem[idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_err_q <= ERR_OK;
         ld_ok     <= 1'b0;
         rsp_off   <= '0;
         rsp_f3    <= '0;
         ld_cnt    <= '0;
         st_cnt    <= '0;
         err_cnt   <= '0;
      end else begin
         if (accept) begin
            rsp_valid <= 1'b1;
            rsp_err_q <= err;
            ld_ok     <= !req_we && (err == ERR_OK);
            rsp_off   <= off;
            rsp_f3    <= req_funct3;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         if (accept) begin
            if (err != ERR_OK) begin
               if (~&err_cnt) err_cnt <= err_cnt + CNT_WIDTH'(1);
            end else if (req_we) begin
               if (~&st_cnt) st_cnt <= st_cnt + CNT_WIDTH'(1);
            end else begin
               if (~&ld_cnt) ld_cnt <= ld_cnt + CNT_WIDTH'(1);
            end
         end
      end
   end

   dmem_ld_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .word   (rd_word),
      .offset (rsp_off),
      .funct3 (rsp_f3),
      .rdata  (al_rdata)
   );

   assign rsp_rdata = ld_ok ? al_rdata : '0;
   assign rsp_err   = rsp_err_q;

endmodule
